// File: rtl/display_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment display path.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the top level.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;
  localparam seg7_t SEG_DASH  = 7'h40;

  // Nibbles A-F are not valid BCD and show a dash so bad upstream data is visible.
  localparam seg7_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-high segment pattern, with forced blanking.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg7_t      seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : SEG_LUT[nibble];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Scans a packed 4-digit BCD word onto a multiplexed 7-segment display, most significant
// digit first, with leading-zero blanking, anode dead time and frame-aligned value updates.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 27_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEAD_CYCLES    = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        blank_lz,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int TICK_DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0]      slot_cnt;
  logic [1:0]            digit_idx;
  logic                  slot_wrap;
  logic                  frame_wrap;

  logic [15:0]           pend_bcd;
  logic [3:0]            pend_dp;
  logic                  pend_flag;
  logic [15:0]           disp_bcd;
  logic [3:0]            disp_dp;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lead_zero;
  logic [3:0]            cur_nibble;
  seg7_t                 cur_seg;
  logic                  in_dead;

  logic [NUM_DIGITS-1:0] an_q;
  seg7_t                 seg_q;
  logic                  dp_q;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (digit_idx == 2'd0);
  assign in_dead    = (slot_cnt < DEAD_END);

  // Digit index counts down so the most significant digit is scanned first in each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= digit_idx - 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + CNT_W'(1);
    end
  end

  // A capture in the same cycle as the frame transfer wins the pending slot and keeps the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_bcd  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_bcd  <= '0;
      disp_dp   <= '0;
    end else begin
      if (frame_wrap && pend_flag) begin
        disp_bcd <= pend_bcd;
        disp_dp  <= pend_dp;
      end
      if (bcd_valid) begin
        pend_bcd  <= bcd_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (frame_wrap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    lz_blank  = '0;
    lead_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_zero   = lead_zero && (disp_bcd[i*4 +: 4] == 4'd0);
      lz_blank[i] = blank_lz && lead_zero;
    end
  end

  assign cur_nibble = disp_bcd[{digit_idx, 2'b00} +: 4];

  seg7_decoder u_decoder (
    .nibble (cur_nibble),
    .blank  (lz_blank[digit_idx]),
    .seg    (cur_seg)
  );

  // Output registers hold active-high values so reset maps to inactive for either polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '0;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b0;
    end else begin
      an_q  <= in_dead ? '0 : digit_onehot(digit_idx);
      seg_q <= cur_seg;
      dp_q  <= disp_dp[digit_idx];
    end
  end

  assign an  = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;
  assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp  = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed self-checking bench for bcd_display_scan with 8-clock slots, 2-clock dead time
// and active-low segments and anodes.
module tb_bcd_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_cmp;
  int n_fail;
  int edges;

  bcd_display_scan #(
    .CLK_FREQ_HZ    (8000),
    .SCAN_HZ        (1000),
    .DEAD_CYCLES    (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .blank_lz  (blank_lz),
    .dp_in     (dp_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; phase 0 is the first digit-0 slot after reset.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic int cur_ph();
    if (edges == 0) return -1;
    return (edges - 1) % 32;
  endfunction

  task automatic wait_phase(input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (cur_ph() == target) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL wait_phase: got phase %0d expected %0d", cur_ph(), target);
    end
  endtask

  task automatic pulse_valid(input logic [15:0] val, input logic [3:0] dps);
    wait_phase(2);
    bcd_in    = val;
    dp_in     = dps;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  // Checks one full display frame (digits 3,2,1,0) starting at the first clock of the digit-3 slot.
  task automatic check_frame(input string tag,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] dp_exp,
                             input int inj1, input logic [15:0] v1,
                             input int inj2, input logic [15:0] v2);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int ph, cnt, dig;
    exp_seg[3] = s3; exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
    n_cmp++;
    if (cur_ph() !== 8) begin
      n_fail++;
      $display("[TB] FAIL %s align: got phase %0d expected 8", tag, cur_ph());
    end
    for (int i = 0; i < 32; i++) begin
      ph  = (8 + i) % 32;
      cnt = ph % 8;
      case (ph / 8)
        0:       dig = 0;
        1:       dig = 3;
        2:       dig = 2;
        default: dig = 1;
      endcase
      exp_an = 4'b1111;
      if (cnt >= 2) exp_an[dig] = 1'b0;
      n_cmp++;
      if (an !== exp_an) begin
        n_fail++;
        $display("[TB] FAIL %s an d%0d c%0d: got %b expected %b", tag, dig, cnt, an, exp_an);
      end
      n_cmp++;
      if (seg !== exp_seg[dig]) begin
        n_fail++;
        $display("[TB] FAIL %s seg d%0d c%0d: got %h expected %h", tag, dig, cnt, seg, exp_seg[dig]);
      end
      n_cmp++;
      if (dp !== dp_exp[dig]) begin
        n_fail++;
        $display("[TB] FAIL %s dp d%0d c%0d: got %b expected %b", tag, dig, cnt, dp, dp_exp[dig]);
      end
      bcd_valid = 1'b0;
      if (i == inj1) begin bcd_in = v1; bcd_valid = 1'b1; end
      if (i == inj2) begin bcd_in = v2; bcd_valid = 1'b1; end
      @(negedge clk);
    end
    bcd_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if (an !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL %s an: got %b expected 1111", tag, an);
    end
    n_cmp++;
    if (seg !== 7'h7F) begin
      n_fail++;
      $display("[TB] FAIL %s seg: got %h expected 7f", tag, seg);
    end
    n_cmp++;
    if (dp !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s dp: got %b expected 1", tag, dp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_idle("reset_initial");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Load a value into pending but reset before the frame boundary transfers it.
    pulse_valid(16'h0999, 4'b0000);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1 check_idle("reset_mid_slot");
    @(negedge clk);
    rst = 1'b0;
    wait_phase(8);
    check_frame("reset_display_zero", 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_basic();
    blank_lz = 1'b0;
    pulse_valid(16'h0255, 4'b0000);
    wait_phase(8);
    check_frame("basic_0255", 7'h40, 7'h24, 7'h12, 7'h12, 4'b1111, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_blanking();
    blank_lz = 1'b1;
    pulse_valid(16'h0007, 4'b0000);
    wait_phase(8);
    check_frame("blank_0007", 7'h7F, 7'h7F, 7'h7F, 7'h78, 4'b1111, -1, 16'h0, -1, 16'h0);
    pulse_valid(16'h0000, 4'b0000);
    wait_phase(8);
    check_frame("blank_0000", 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111, -1, 16'h0, -1, 16'h0);
    pulse_valid(16'h0305, 4'b0000);
    wait_phase(8);
    check_frame("blank_0305", 7'h7F, 7'h30, 7'h40, 7'h12, 4'b1111, -1, 16'h0, -1, 16'h0);
    blank_lz = 1'b0;
  endtask

  task automatic test_tear_free();
    pulse_valid(16'h4321, 4'b0000);
    wait_phase(8);
    check_frame("tear_load_4321", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, -1, 16'h0, -1, 16'h0);
    check_frame("tear_hold_4321", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, 4, 16'h1234, 14, 16'h5678);
    check_frame("tear_show_5678", 7'h12, 7'h02, 7'h78, 7'h00, 4'b1111, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_invalid_dp();
    pulse_valid(16'h00A3, 4'b0010);
    wait_phase(8);
    check_frame("invalid_dp_00A3", 7'h40, 7'h40, 7'h3F, 7'h30, 4'b1101, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_wrap();
    for (int f = 0; f < 3; f++) begin
      check_frame("wrap_frames", 7'h40, 7'h40, 7'h3F, 7'h30, 4'b1101, -1, 16'h0, -1, 16'h0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    bcd_in    = 16'h0;
    bcd_valid = 1'b0;
    blank_lz  = 1'b0;
    dp_in     = 4'b0;
    test_reset();
    test_basic();
    test_blanking();
    test_tear_free();
    test_invalid_dp();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
